// File: rtl/sdram_device_responder_if.sv
// SDR SDRAM bus between controller (master) and device responder (slave).
// Commands and write data flow master->slave; read data and its valid flow back.
interface sdram_device_responder_if #(
    parameter int BANK_WIDTH    = 2,
    parameter int SDRADDR_WIDTH = 13
);
    logic                     clock_enable;
    logic                     cs_n;
    logic                     ras_n;
    logic                     cas_n;
    logic                     we_n;
    logic [BANK_WIDTH-1:0]    bank_addr;
    logic [SDRADDR_WIDTH-1:0] addr;
    logic [15:0]              dq_in;
    logic                     data_mask_low;
    logic                     data_mask_high;
    logic [15:0]              dq_out;
    logic                     dq_out_en;

    modport master (
        output clock_enable, cs_n, ras_n, cas_n, we_n, bank_addr, addr,
               dq_in, data_mask_low, data_mask_high,
        input  dq_out, dq_out_en
    );

    modport slave (
        input  clock_enable, cs_n, ras_n, cas_n, we_n, bank_addr, addr,
               dq_in, data_mask_low, data_mask_high,
        output dq_out, dq_out_en
    );
endinterface

// File: rtl/sdram_device_responder.sv
// SDR SDRAM device-side responder on a small word array; read data CL (2/3) edges after READ, no backpressure.
// Optional sticky protocol checker is compiled in with `define SDRAM_RESP_CHECK_EN.
module sdram_device_responder #(
    parameter int ROW_WIDTH      = 13,
    parameter int COL_WIDTH      = 9,
    parameter int BANK_WIDTH     = 2,
    parameter int SDRADDR_WIDTH  = (ROW_WIDTH > COL_WIDTH) ? ROW_WIDTH : COL_WIDTH,
    parameter int MEM_ROW_BITS   = 2,
    parameter int T_RCD          = 2,
    parameter int REF_MAX_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    sdram_device_responder_if.slave   bus,
    output logic                      init_done,
    output logic [9:0]                mode_reg,
    output logic [6:0]                err_flags
);
    localparam int NUM_BANKS = 1 << BANK_WIDTH;
    localparam int IDX_WIDTH = BANK_WIDTH + MEM_ROW_BITS + COL_WIDTH;

    localparam logic [2:0] ST_WAIT_PALL = 3'd0;
    localparam logic [2:0] ST_WAIT_REF1 = 3'd1;
    localparam logic [2:0] ST_WAIT_REF2 = 3'd2;
    localparam logic [2:0] ST_WAIT_MRS  = 3'd3;
    localparam logic [2:0] ST_READY     = 3'd4;

    localparam logic [2:0] CMD_NOP   = 3'b111;
    localparam logic [2:0] CMD_ACT   = 3'b011;
    localparam logic [2:0] CMD_READ  = 3'b101;
    localparam logic [2:0] CMD_WRITE = 3'b100;
    localparam logic [2:0] CMD_PRE   = 3'b010;
    localparam logic [2:0] CMD_REF   = 3'b001;
    localparam logic [2:0] CMD_MRS   = 3'b000;

    logic [2:0]              state;
    logic [2:0]              cmd;
    logic                    is_act, is_read, is_write, is_pre, is_ref, is_mrs;
    logic                    ready, mrs_accept, auto_pre, sel_open, access_ok;
    logic [BANK_WIDTH-1:0]   ba;
    logic [NUM_BANKS-1:0]    bank_open;
    logic [MEM_ROW_BITS-1:0] open_row [NUM_BANKS];
    logic [IDX_WIDTH-1:0]    word_idx;
    logic [15:0]             mem [1 << IDX_WIDTH];
    logic                    s1_vld, s2_vld;
    logic [15:0]             s1_dat, s2_dat;
    logic                    cl2;
    logic                    unused_addr_bits;

    // CKE low or chip deselected both collapse to NOP
    assign cmd        = (bus.clock_enable && !bus.cs_n) ? {bus.ras_n, bus.cas_n, bus.we_n} : CMD_NOP;
    assign is_act     = (cmd == CMD_ACT);
    assign is_read    = (cmd == CMD_READ);
    assign is_write   = (cmd == CMD_WRITE);
    assign is_pre     = (cmd == CMD_PRE);
    assign is_ref     = (cmd == CMD_REF);
    assign is_mrs     = (cmd == CMD_MRS);
    assign ready      = (state == ST_READY);
    assign init_done  = ready;
    assign mrs_accept = is_mrs && (ready || state == ST_WAIT_MRS);
    assign auto_pre   = bus.addr[10];
    assign ba         = bus.bank_addr;
    assign sel_open   = bank_open[ba];
    assign access_ok  = !rst && ready && sel_open && (is_read || is_write);
    assign word_idx   = {ba, open_row[ba], bus.addr[COL_WIDTH-1:0]};
    assign cl2        = (mode_reg[6:4] == 3'd2);
    assign unused_addr_bits = ^bus.addr[SDRADDR_WIDTH-1:11];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_WAIT_PALL;
        end else begin
            case (state)
                ST_WAIT_PALL: if (is_pre && auto_pre) state <= ST_WAIT_REF1;
                ST_WAIT_REF1: if (is_ref) state <= ST_WAIT_REF2;
                ST_WAIT_REF2: if (is_ref) state <= ST_WAIT_MRS;
                ST_WAIT_MRS:  if (is_mrs) state <= ST_READY;
                ST_READY:     state <= ST_READY;
                default:      state <= ST_WAIT_PALL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_reg <= '0;
        end else if (mrs_accept) begin
            mode_reg <= bus.addr[9:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_open <= '0;
        end else if (ready) begin
            if (is_act) begin
                bank_open[ba] <= 1'b1;
            end else if (is_pre) begin
                if (auto_pre) bank_open <= '0;
                else          bank_open[ba] <= 1'b0;
            end else if (access_ok && auto_pre) begin
                bank_open[ba] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && ready && is_act) begin
            open_row[ba] <= bus.addr[MEM_ROW_BITS-1:0];
        end
    end

    // Array is never cleared; the read port samples at the command edge
    always_ff @(posedge clk) begin
        if (access_ok && is_write) begin
            if (!bus.data_mask_low)  mem[word_idx][7:0]  <= bus.dq_in[7:0];
            if (!bus.data_mask_high) mem[word_idx][15:8] <= bus.dq_in[15:8];
        end
        s1_dat <= mem[word_idx];
        s2_dat <= s1_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld        <= 1'b0;
            s2_vld        <= 1'b0;
            bus.dq_out_en <= 1'b0;
            bus.dq_out    <= '0;
        end else begin
            s1_vld <= access_ok && is_read;
            s2_vld <= s1_vld;
            if (cl2) begin
                bus.dq_out_en <= s1_vld;
                bus.dq_out    <= s1_vld ? s1_dat : 16'h0;
            end else begin
                bus.dq_out_en <= s2_vld;
                bus.dq_out    <= s2_vld ? s2_dat : 16'h0;
            end
        end
    end

`ifdef SDRAM_RESP_CHECK_EN
    localparam int RCD_W = $clog2(T_RCD + 1);
    localparam int REF_W = $clog2(REF_MAX_CYCLES + 1);
    localparam logic [RCD_W-1:0] RCD_MAX = RCD_W'(T_RCD - 1);
    localparam logic [REF_W-1:0] REF_MAX = REF_W'(REF_MAX_CYCLES);

    logic [RCD_W-1:0] rcd_cnt [NUM_BANKS];
    logic [REF_W-1:0] ref_cnt;
    logic [6:0]       err_set;

    always_comb begin
        err_set    = '0;
        err_set[0] = !ready && (is_act || is_read || is_write);
        err_set[1] = ready && is_act && sel_open;
        err_set[2] = ready && (is_read || is_write) && !sel_open;
        err_set[3] = access_ok && (rcd_cnt[ba] < RCD_MAX);
        err_set[4] = ready && is_ref && (|bank_open);
        err_set[5] = ready && !is_ref && (ref_cnt == REF_MAX);
        err_set[6] = mrs_accept && (!(bus.addr[6:4] == 3'd2 || bus.addr[6:4] == 3'd3)
                                    || bus.addr[2:0] != 3'b000);
    end

    // Per-bank cycles since ACT, saturating once T_RCD is satisfied
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (rst)                                          rcd_cnt[i] <= '0;
            else if (ready && is_act && ba == BANK_WIDTH'(i)) rcd_cnt[i] <= '0;
            else if (rcd_cnt[i] != RCD_MAX)                   rcd_cnt[i] <= rcd_cnt[i] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || is_ref)                   ref_cnt <= '0;
        else if (ready && ref_cnt != REF_MAX) ref_cnt <= ref_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) err_flags <= '0;
        else     err_flags <= err_flags | err_set;
    end
`else
    logic unused_cfg;
    assign unused_cfg = (T_RCD > 0) ^ (REF_MAX_CYCLES > 0);
    assign err_flags  = '0;
`endif
endmodule

// File: tb/tb_sdram_device_responder.sv
// Directed bench for sdram_device_responder against a transaction-level model of the SDRAM rules.
module tb_sdram_device_responder;
`ifdef SDRAM_RESP_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif
    localparam int T_RCD   = 2;
    localparam int REF_MAX = 1024;
    localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD = 3'b101, C_WR = 3'b100,
                           C_PRE = 3'b010, C_REF = 3'b001, C_MRS = 3'b000;

    logic clk = 1'b0;
    logic rst;
    logic init_done;
    logic [9:0] mode_reg;
    logic [6:0] err_flags;

    always #5 clk = ~clk;

    sdram_device_responder_if #(.BANK_WIDTH(2), .SDRADDR_WIDTH(13)) bus ();

    sdram_device_responder dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .init_done (init_done),
        .mode_reg  (mode_reg),
        .err_flags (err_flags)
    );

    typedef struct { int due; logic [15:0] dat; } beat_t;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    bit          m_ready;
    int          m_stage;
    bit          m_open [4];
    int          m_row [4];
    int          m_act_cyc [4];
    logic [9:0]  m_mode;
    logic [6:0]  m_flags;
    int          m_ref_ref;
    logic [15:0] m_mem [int];
    beat_t       m_beats [$];
    int          dut_beat_edge = -1;
    logic [15:0] dut_beat_dat = 16'h0;
    int          dut_beat_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    endtask

    function automatic bit cl_ok(input logic [9:0] v);
        return (v[6:4] == 3'd2 || v[6:4] == 3'd3) && v[2:0] == 3'b000;
    endfunction

    // Model: applies one sampled command at edge number cyc
    task automatic model_update(input bit r, input bit cke, input logic [2:0] rcw_in, input int ba,
                                input int ad, input logic [15:0] d, input bit dmh, input bit dml);
        logic [2:0]  rcw;
        int          cl, idx;
        logic [15:0] w;
        rcw = cke ? rcw_in : C_NOP;
        cl  = (m_mode[6:4] == 3'd2) ? 2 : 3;
        if (r) begin
            m_ready = 0; m_stage = 0; m_mode = '0; m_flags = '0;
            for (int b = 0; b < 4; b++) m_open[b] = 0;
            m_beats.delete();
            return;
        end
        if (!m_ready) begin
            if (rcw == C_ACT || rcw == C_RD || rcw == C_WR) m_flags[0] = 1'b1;
            if (rcw == C_REF) m_ref_ref = cyc;
            if (m_stage == 0 && rcw == C_PRE && ad[10]) m_stage = 1;
            else if ((m_stage == 1 || m_stage == 2) && rcw == C_REF) m_stage++;
            else if (m_stage == 3 && rcw == C_MRS) begin
                m_mode = 10'(ad);
                if (!cl_ok(10'(ad))) m_flags[6] = 1'b1;
                m_ready = 1; m_ref_ref = cyc;
            end
            return;
        end
        if (rcw != C_REF && cyc - m_ref_ref > REF_MAX) m_flags[5] = 1'b1;
        case (rcw)
            C_ACT: begin
                if (m_open[ba]) m_flags[1] = 1'b1;
                m_open[ba] = 1; m_row[ba] = ad; m_act_cyc[ba] = cyc;
            end
            C_RD, C_WR: begin
                if (!m_open[ba]) m_flags[2] = 1'b1;
                else begin
                    if (cyc - m_act_cyc[ba] < T_RCD) m_flags[3] = 1'b1;
                    idx = ba * 2048 + (m_row[ba] % 4) * 512 + (ad % 512);
                    if (rcw == C_WR) begin
                        w = m_mem.exists(idx) ? m_mem[idx] : 16'h0;
                        if (!dml) w[7:0]  = d[7:0];
                        if (!dmh) w[15:8] = d[15:8];
                        m_mem[idx] = w;
                    end else begin
                        m_beats.push_back('{due: cyc + cl - 1, dat: m_mem[idx]});
                    end
                    if (ad[10]) m_open[ba] = 0;
                end
            end
            C_PRE: begin
                if (ad[10]) for (int b = 0; b < 4; b++) m_open[b] = 0;
                else m_open[ba] = 0;
            end
            C_REF: begin
                if (m_open[0] || m_open[1] || m_open[2] || m_open[3]) m_flags[4] = 1'b1;
                m_ref_ref = cyc;
            end
            C_MRS: begin
                m_mode = 10'(ad);
                if (!cl_ok(10'(ad))) m_flags[6] = 1'b1;
            end
            default: ;
        endcase
    endtask

    task automatic compare();
        bit exp_en;
        exp_en = (m_beats.size() > 0) && (m_beats[0].due == cyc);
        check("dq_out_en", 32'(bus.dq_out_en), 32'(exp_en));
        if (exp_en) begin
            check("dq_out", 32'(bus.dq_out), 32'(m_beats[0].dat));
            void'(m_beats.pop_front());
        end
        check("init_done", 32'(init_done), 32'(m_ready));
        check("mode_reg", 32'(mode_reg), 32'(m_mode));
        check("err_flags", 32'(err_flags), CHECK_EN ? 32'(m_flags) : 32'h0);
        if (bus.dq_out_en) begin
            dut_beat_edge = cyc + 1;
            dut_beat_dat  = bus.dq_out;
            dut_beat_cnt++;
        end
    endtask

    task automatic step(input bit r, input bit cke, input logic [2:0] rcw, input int ba, input int ad,
                        input logic [15:0] d, input bit dmh, input bit dml);
        rst = r;
        bus.clock_enable = cke; bus.cs_n = 1'b0;
        {bus.ras_n, bus.cas_n, bus.we_n} = rcw;
        bus.bank_addr = 2'(ba); bus.addr = 13'(ad); bus.dq_in = d;
        bus.data_mask_high = dmh; bus.data_mask_low = dml;
        @(posedge clk);
        cyc++;
        model_update(r, cke, rcw, ba, ad, d, dmh, dml);
        @(negedge clk);
        compare();
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) step(0, 1, C_NOP, 0, 0, 16'h0, 0, 0);
    endtask
    task automatic act(input int ba, input int row); step(0, 1, C_ACT, ba, row, 16'h0, 0, 0); endtask
    task automatic rd(input int ba, input int col, input bit ap);
        step(0, 1, C_RD, ba, col | (ap ? 1024 : 0), 16'h0, 0, 0);
    endtask
    task automatic wr(input int ba, input int col, input logic [15:0] d, input bit ap, input bit dmh);
        step(0, 1, C_WR, ba, col | (ap ? 1024 : 0), d, dmh, 0);
    endtask
    task automatic pre_all(); step(0, 1, C_PRE, 0, 1024, 16'h0, 0, 0); endtask
    task automatic refresh(); step(0, 1, C_REF, 0, 0, 16'h0, 0, 0); endtask
    task automatic mrs(input int v); step(0, 1, C_MRS, 0, v, 16'h0, 0, 0); endtask
    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) step(1, 1, C_NOP, 0, 0, 16'h0, 0, 0);
    endtask
    task automatic init_seq(input bit extra_ref);
        pre_all(); nop(1); refresh(); nop(1); refresh(); nop(1);
        if (extra_ref) refresh();
        mrs(10'b1000110000);
    endtask

    int n0, c0;

    initial begin
        reset_cycles(2);
        check("rst_dq_out", 32'(bus.dq_out), 32'h0);
        check("rst_dq_out_en", 32'(bus.dq_out_en), 32'h0);
        check("rst_init_done", 32'(init_done), 32'h0);

        init_seq(1);
        check("init_done_lit", 32'(init_done), 32'h1);
        check("init_mode_lit", 32'(mode_reg), 32'h230);
        check("init_flags_lit", 32'(err_flags), 32'h0);

        // CL=3 write/read round trip
        act(1, 5); nop(1); wr(1, 'h1A, 16'hBEEF, 1, 0);
        act(1, 5); nop(1); rd(1, 'h1A, 0); n0 = cyc;
        nop(4);
        check("beef_dat", 32'(dut_beat_dat), 32'hBEEF);
        check("beef_edge", 32'(dut_beat_edge), 32'(n0 + 3));

        // byte mask, write-then-read next edge, CKE gating
        act(2, 3); nop(1); wr(2, 5, 16'h1234, 0, 0); wr(2, 5, 16'hABCD, 0, 1); rd(2, 5, 0);
        nop(4);
        check("mask_dat", 32'(dut_beat_dat), 32'h12CD);
        c0 = dut_beat_cnt;
        step(0, 0, C_RD, 2, 5, 16'h0, 0, 0); nop(4);
        check("cke_no_beat", 32'(dut_beat_cnt), 32'(c0));
        pre_all();

        // row aliasing above MEM_ROW_BITS
        act(3, 4); nop(1); wr(3, 7, 16'h0F0F, 1, 0);
        act(3, 0); nop(1); rd(3, 7, 1); nop(4);
        check("alias_dat", 32'(dut_beat_dat), 32'h0F0F);

        // CL=2 and back-to-back reads
        mrs(10'h220);
        act(0, 1); nop(1); wr(0, 3, 16'h5555, 0, 0); wr(0, 4, 16'hAAAA, 0, 0);
        c0 = dut_beat_cnt;
        rd(0, 3, 0); n0 = cyc; rd(0, 4, 1);
        check("cl2_first_edge", 32'(dut_beat_edge), 32'(n0 + 2));
        check("cl2_first_dat", 32'(dut_beat_dat), 32'h5555);
        nop(3);
        check("cl2_beats", 32'(dut_beat_cnt), 32'(c0 + 2));
        check("cl2_second_edge", 32'(dut_beat_edge), 32'(n0 + 3));
        check("cl2_second_dat", 32'(dut_beat_dat), 32'hAAAA);

        // protocol violations
        act(0, 1); act(0, 1); rd(0, 3, 0); nop(3);
        refresh();
        c0 = dut_beat_cnt;
        rd(2, 0, 0); nop(3);
        check("closed_no_beat", 32'(dut_beat_cnt), 32'(c0));
        mrs(10'h227); nop(1); pre_all(); refresh();
        check("viol_flags_lit", 32'(err_flags), CHECK_EN ? 32'h5E : 32'h0);

        // reset while a read is in flight
        c0 = dut_beat_cnt;
        act(1, 5); nop(1); rd(1, 'h1A, 0); reset_cycles(2); nop(4);
        check("rst_flush", 32'(dut_beat_cnt), 32'(c0));
        check("rst_flags_lit", 32'(err_flags), 32'h0);
        check("rst_init_lit", 32'(init_done), 32'h0);

        // command before ready, then refresh starvation
        act(0, 0);
        init_seq(0);
        nop(1000);
        check("ref_ok_flags", 32'(err_flags), CHECK_EN ? 32'h01 : 32'h0);
        nop(30);
        check("ref_late_flags", 32'(err_flags), CHECK_EN ? 32'h21 : 32'h0);
        reset_cycles(1);
        check("final_flags", 32'(err_flags), 32'h0);
        check("final_init", 32'(init_done), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
